// File: rtl/tbman_print_uart.sv
// Debug print port: bytes and hex-formatted words are queued in a small FIFO
// and shifted out as 8N1 UART frames.
module tbman_print_uart #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    print_i,
    input  logic                          print_wen,
    input  logic [31:0]                   putint_i,
    input  logic                          putint_wen,
    input  logic                          ovf_clr,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL  = LW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_RELOAD = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    logic          r_fmt_active;
    logic [3:0]    r_fmt_cnt;
    logic [31:0]   r_fmt_word;
    tx_state_t     r_state;
    logic [15:0]   r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;

    logic [3:0]    w_nib;
    logic [7:0]    w_fmt_byte;
    logic          w_push_req;
    logic [7:0]    w_push_data;
    logic          w_full;
    logic          w_push_ok;
    logic          w_drop;
    logic          w_pop;
    logic          w_bit_end;
    tx_state_t     w_state_nxt;
    logic [15:0]   w_baud_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_tx_nxt;

    // The formatter shifts its word left, so the digit to emit is always the top nibble.
    assign w_nib = r_fmt_word[31:28];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_fmt_byte = 8'h0A;
        if (r_fmt_cnt != 4'd8)
            w_fmt_byte = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h57 + {4'h0, w_nib});
    end

    // An active formatter owns the push port; a strobe arriving then is lost.
    assign w_push_req  = r_fmt_active | print_wen;
    assign w_push_data = r_fmt_active ? w_fmt_byte : print_i;
    assign w_full      = (r_level == FULL_LEVEL);
    assign w_push_ok   = w_push_req & ~w_full;
    assign w_drop      = (w_push_req & w_full) | (r_fmt_active & (print_wen | putint_wen));

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = 1'b1;
        w_pop       = 1'b0;
        w_bit_end   = (r_baud == 16'd0);
        if (r_state != S_IDLE && !w_bit_end)
            w_baud_nxt = r_baud - 16'd1;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_baud_nxt  = BAUD_RELOAD;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx_nxt = 1'b0;
                if (w_bit_end) begin
                    w_baud_nxt  = BAUD_RELOAD;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_bit_end) begin
                    w_baud_nxt  = BAUD_RELOAD;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7)
                        w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_fmt_active <= 1'b0;
            r_fmt_cnt    <= 4'd0;
            r_fmt_word   <= 32'h0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop};
            if (w_drop)
                r_overflow <= 1'b1;
            else if (ovf_clr)
                r_overflow <= 1'b0;
            if (r_fmt_active) begin
                r_fmt_word <= {r_fmt_word[27:0], 4'h0};
                r_fmt_cnt  <= r_fmt_cnt + 4'd1;
                if (r_fmt_cnt == 4'd8)
                    r_fmt_active <= 1'b0;
            end else if (putint_wen) begin
                r_fmt_word   <= putint_i;
                r_fmt_cnt    <= 4'd0;
                r_fmt_active <= 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push_ok && !rst)
            r_mem[r_wr_ptr] <= w_push_data;
    end

    assign tx       = r_tx;
    assign busy     = (r_level != '0) | r_fmt_active | (r_state != S_IDLE);
    assign overflow = r_overflow;
    assign level    = r_level;

endmodule
